mult_datapath: RTL and testbench

- Datapath of the shift-add multiplier: accumulator/multiplier register, adder and bit counter.
- Sits directly downstream of the multiplier Control FSM and executes its Load, Ad and Sh commands.
- Feeds back M (current multiplier LSB) and K (last shift pending) to Control.
- Exposes the 2N-bit product, valid whenever Control signals Done.

---
 rtl/mult_datapath_if.sv | 40 ++++
 rtl/mult_datapath.sv | 69 ++++++
 tb/tb_mult_datapath.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Command/status bundle between the shift-add multiplier Control FSM and its datapath.
//
// Handshake: there is no valid/ready pair. Load, Ad and Sh are single-cycle
// level commands that the datapath acts on at every rising clock edge where
// they are high, with priority Load > {Ad, Sh}. Mcand is sampled on every edge
// where Ad is high, and Mplier only on Load. M, K and Product are driven from
// registers only, so Control can read them in the same cycle it decides its
// next command without creating a combinational loop.
interface mult_datapath_if #(
    parameter int N = 4
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Control -> datapath commands and operands
    logic             Load;
    logic             Ad;
    logic             Sh;
    logic [N-1:0]     Mcand;
    logic [N-1:0]     Mplier;

    // Datapath -> Control status and result
    logic             M;
    logic             K;
    logic [2*N-1:0]   Product;

    // Observation of the internal state: the full accumulator including the
    // carry bit, and the step counter
    logic [2*N:0]     dbg_acc;
    logic [CW-1:0]    dbg_cnt;

    modport master (
        output Load, Ad, Sh, Mcand, Mplier,
        input  M, K, Product, dbg_acc, dbg_cnt
    );

    modport slave (
        input  Load, Ad, Sh, Mcand, Mplier,
        output M, K, Product, dbg_acc, dbg_cnt
    );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: a (2N+1)-bit accumulator/multiplier register,
// an (N+1)-bit adder that keeps the carry, and a step counter. It executes the
// Load/Ad/Sh commands of the Control FSM and reports M (current multiplier
// bit) and K (last shift pending) back to it.
module mult_datapath #(
    parameter int N = 4
) (
    input  logic Clk,
    input  logic Rst,
    mult_datapath_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 2 * N + 1;

    // ACC[2N:N] is the partial-product upper part A (carry in bit 2N),
    // ACC[N-1:0] is Q, the multiplier bits still to be consumed.
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          cnt_last;
    logic [N:0]    sum;
    logic [AW-1:0] acc_added;

    // K is also the wrap point for the counter, so non-power-of-two N still
    // counts exactly N shifts per multiply.
    assign cnt_last = (cnt_q == CW'(N - 1));

    // Adder: upper N bits of the accumulator plus the multiplicand, carry kept.
    assign sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, bus.Mcand};

    // Accumulator after an optional add; a fused Ad+Sh shifts this value, so
    // the one-edge and two-edge sequences give the same result.
    assign acc_added = bus.Ad ? {sum, acc_q[N-1:0]} : acc_q;

    // Next-state selection: Load beats Ad/Sh; with no command everything holds.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (bus.Load) begin
            acc_d = {{(N + 1){1'b0}}, bus.Mplier};
            cnt_d = '0;
        end else if (bus.Sh) begin
            acc_d = acc_added >> 1;
            cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        end else begin
            acc_d = acc_added;
        end
    end

    // State registers; reset dominates every command.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs come straight from the registers.
    assign bus.M       = acc_q[0];
    assign bus.K       = cnt_last;
    assign bus.Product = acc_q[2*N-1:0];
    assign bus.dbg_acc = acc_q;
    assign bus.dbg_cnt = cnt_q;
endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath at N=4 and N=8. Expected products are
// queued at Load time and popped once the final shift has happened.
module tb_mult_datapath;
    logic Clk;
    logic Rst;

    mult_datapath_if #(.N(4)) bus4 ();
    mult_datapath_if #(.N(8)) bus8 ();

    mult_datapath #(.N(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));
    mult_datapath #(.N(8)) dut8 (.Clk(Clk), .Rst(Rst), .bus(bus8));

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one command cycle on the N=4 instance; returns at the following negedge
    task automatic cyc4(input logic l, input logic a, input logic s);
        bus4.Load = l;
        bus4.Ad   = a;
        bus4.Sh   = s;
        @(posedge Clk);
        @(negedge Clk);
        bus4.Load = 1'b0;
        bus4.Ad   = 1'b0;
        bus4.Sh   = 1'b0;
    endtask

    task automatic cyc8(input logic l, input logic a, input logic s);
        bus8.Load = l;
        bus8.Ad   = a;
        bus8.Sh   = s;
        @(posedge Clk);
        @(negedge Clk);
        bus8.Load = 1'b0;
        bus8.Ad   = 1'b0;
        bus8.Sh   = 1'b0;
    endtask

    // Full Control sequence at N=4. Ad decisions come from the known
    // multiplier bits; the DUT's M is only compared, never used.
    task automatic run4(input logic [3:0] mc, input logic [3:0] mp,
                        input bit fused, input bit chk_carry, input string tag);
        logic [31:0] exp;
        bus4.Mcand  = mc;
        bus4.Mplier = mp;
        exp_q.push_back(32'(mc) * 32'(mp));
        cyc4(1'b1, 1'b0, 1'b0);
        bus4.Mplier = 4'($urandom_range(0, 15));
        chk({tag, "_cnt_after_load"}, 32'(bus4.dbg_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_M"}, 32'(bus4.M), 32'(mp[i]));
            chk({tag, "_K"}, 32'(bus4.K), (i == 3) ? 32'd1 : 32'd0);
            if (fused) begin
                cyc4(1'b0, mp[i], 1'b1);
            end else begin
                if (mp[i]) begin
                    cyc4(1'b0, 1'b1, 1'b0);
                    if (chk_carry && i == 3)
                        chk({tag, "_carry"}, 32'(bus4.dbg_acc[8]), 32'd1);
                end
                cyc4(1'b0, 1'b0, 1'b1);
            end
        end
        exp = exp_q.pop_front();
        chk({tag, "_product"}, 32'(bus4.Product), exp);
        chk({tag, "_K_done"}, 32'(bus4.K), 32'd0);
        chk({tag, "_acc8"}, 32'(bus4.dbg_acc[8]), 32'd0);
        chk({tag, "_cnt_done"}, 32'(bus4.dbg_cnt), 32'd0);
    endtask

    task automatic run8(input logic [7:0] mc, input logic [7:0] mp, input string tag);
        logic [31:0] exp;
        bus8.Mcand  = mc;
        bus8.Mplier = mp;
        exp_q.push_back(32'(mc) * 32'(mp));
        cyc8(1'b1, 1'b0, 1'b0);
        bus8.Mplier = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_M"}, 32'(bus8.M), 32'(mp[i]));
            chk({tag, "_K"}, 32'(bus8.K), (i == 7) ? 32'd1 : 32'd0);
            if (mp[i])
                cyc8(1'b0, 1'b1, 1'b0);
            cyc8(1'b0, 1'b0, 1'b1);
        end
        exp = exp_q.pop_front();
        chk({tag, "_product"}, 32'(bus8.Product), exp);
        chk({tag, "_K_done"}, 32'(bus8.K), 32'd0);
        chk({tag, "_acc16"}, 32'(bus8.dbg_acc[16]), 32'd0);
        chk({tag, "_cnt_done"}, 32'(bus8.dbg_cnt), 32'd0);
    endtask

    initial begin
        Rst = 1'b1;
        bus4.Load = 1'b0; bus4.Ad = 1'b0; bus4.Sh = 1'b0;
        bus4.Mcand = '0;  bus4.Mplier = '0;
        bus8.Load = 1'b0; bus8.Ad = 1'b0; bus8.Sh = 1'b0;
        bus8.Mcand = '0;  bus8.Mplier = '0;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        // reset state
        chk("rst_product", 32'(bus4.Product), 32'd0);
        chk("rst_M", 32'(bus4.M), 32'd0);
        chk("rst_K", 32'(bus4.K), 32'd0);
        chk("rst_acc", 32'(bus4.dbg_acc), 32'd0);
        chk("rst8_product", 32'(bus8.Product), 32'd0);

        // normal multiply 13 x 11 = 143
        run4(4'd13, 4'd11, 1'b0, 1'b0, "t1");

        // extra shifts beyond N: keep shifting, K re-asserts at count 3
        for (int k = 1; k <= 4; k++) begin
            cyc4(1'b0, 1'b0, 1'b1);
            chk("extra_sh_product", 32'(bus4.Product), 32'h8F >> k);
            chk("extra_sh_K", 32'(bus4.K), (k == 3) ? 32'd1 : 32'd0);
        end

        // extremes
        run4(4'd15, 4'd15, 1'b0, 1'b1, "t2_max");
        run4(4'd9, 4'd0, 1'b0, 1'b0, "t2_zero");

        // fused add-shift
        run4(4'd13, 4'd11, 1'b1, 1'b0, "t3_fused");

        // priority: Load over Ad/Sh
        bus4.Mcand  = 4'd13;
        bus4.Mplier = 4'd5;
        cyc4(1'b1, 1'b1, 1'b1);
        chk("t4_load_acc", 32'(bus4.dbg_acc), 32'd5);
        chk("t4_load_cnt", 32'(bus4.dbg_cnt), 32'd0);
        chk("t4_load_M", 32'(bus4.M), 32'd1);
        chk("t4_load_K", 32'(bus4.K), 32'd0);

        // priority: Rst over Load
        Rst = 1'b1;
        cyc4(1'b1, 1'b0, 1'b0);
        Rst = 1'b0;
        chk("t4_rst_acc", 32'(bus4.dbg_acc), 32'd0);
        chk("t4_rst_cnt", 32'(bus4.dbg_cnt), 32'd0);

        // reset mid-operation, then a fresh multiply
        bus4.Mcand  = 4'd13;
        bus4.Mplier = 4'd11;
        cyc4(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc4(1'b0, 1'b1, 1'b0);
            cyc4(1'b0, 1'b0, 1'b1);
        end
        chk("t5_cnt_mid", 32'(bus4.dbg_cnt), 32'd2);
        Rst = 1'b1;
        cyc4(1'b0, 1'b1, 1'b1);
        Rst = 1'b0;
        chk("t5_product", 32'(bus4.Product), 32'd0);
        chk("t5_M", 32'(bus4.M), 32'd0);
        chk("t5_K", 32'(bus4.K), 32'd0);
        run4(4'd6, 4'd7, 1'b0, 1'b0, "t5_fresh");

        // random operands, both sequencing styles
        for (int r = 0; r < 6; r++)
            run4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 (r % 2) == 1, 1'b0, "rand4");

        // N=8 sweep
        run8(8'd255, 8'd255, "t6_max");
        for (int r = 0; r < 3; r++)
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand8");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
